change_hopper_ctrl: RTL and testbench
=====================================

Name: change_hopper_ctrl

Overview:
- Consumer end of the change interface driven by the vending core: it accepts the one-cycle nickel_out / dime_out / two_dime_out pulses and turns them into physical coin ejections on the nickel and dime hoppers.
- Buffers change requests in a small FIFO and runs a fire/ack handshake with each hopper.
- Tracks hopper coin inventory, flags short-change, and latches a sticky jam fault on ack timeout.
- Sits between the voted vending outputs and the hopper actuator pins.

Parameters:
- QDEPTH, 4: change-request FIFO depth in entries; power of 2, minimum 2.
- TIMEOUT, 15: cycles fire may stay high without ack before jam; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- nickel_out  input  1  one-cycle request: eject 1 nickel.
- dime_out  input  1  one-cycle request: eject 1 dime.
- two_dime_out  input  1  one-cycle request: eject 2 dimes.
- load  input  1  load hopper inventory counters.
- nickels  input  8  nickel inventory value loaded on load.
- dimes  input  8  dime inventory value loaded on load.
- nickel_ack  input  1  one-cycle pulse from the nickel hopper sensor when one coin has been ejected.
- dime_ack  input  1  one-cycle pulse from the dime hopper sensor when one coin has been ejected.
- nickel_fire  output  1  nickel hopper actuator; level, held until ack.
- dime_fire  output  1  dime hopper actuator; level, held until ack.
- busy  output  1  FSM not IDLE, or FIFO not empty.
- queue_full  output  1  FIFO holds QDEPTH entries.
- overflow  output  1  sticky: a request arrived while the FIFO was full.
- short_change  output  1  sticky: a coin was owed but its inventory was 0.
- jam  output  1  sticky: ack timeout.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; FIFO empty; FSM IDLE.
  - Inventory counters 0; timer 0.
- Enqueue:
  - Any cycle with (nickel_out | dime_out | two_dime_out) = 1 pushes one entry {n, d, dd} holding the three input bits.
  - Simultaneous pulses share one entry.
  - If the FIFO is full, the entry is dropped and overflow is set.
  - A push and a pop in the same cycle while the FIFO is full is accepted; the pop frees the slot first.
- Entry decode:
  - nickels owed = n (0..1).
  - dimes owed = d + 2*dd (0..3).
  - An entry with all bits 0 never exists.
- FSM states: IDLE, POP, NFIRE, DFIRE, JAM.
- IDLE:
  - If the FIFO is non-empty → POP.
- POP (1 cycle):
  - Dequeue the head into n_rem (1b) and d_rem (2b).
  - Go to NFIRE if n_rem > 0, else DFIRE.
- NFIRE:
  - If nickel inventory = 0: set short_change, clear n_rem, → DFIRE. No fire is asserted.
  - Otherwise: nickel_fire = 1 from the cycle after entry; the timer counts fire-high cycles.
  - On nickel_ack: in the next cycle nickel_fire = 0, inventory decrements by 1, n_rem clears, the timer clears, → DFIRE.
- DFIRE:
  - If d_rem = 0 → IDLE.
  - If dime inventory = 0: set short_change, clear d_rem, → IDLE.
  - Otherwise: assert dime_fire.
  - On dime_ack: inventory decrements by 1 and d_rem decrements by 1.
  - dime_fire drops for at least one cycle between consecutive coins; the timer restarts per coin.
  - When d_rem reaches 0 → IDLE.
- Latency: a lone request in IDLE with an empty FIFO gives first fire high 3 cycles after the request pulse (push, POP, fire).
- Timeout:
  - If the timer reaches TIMEOUT with fire still high and no ack → JAM.
  - In JAM: both fire outputs 0, jam = 1, the FIFO keeps accepting (and overflowing).
  - JAM is left only by reset.
- Spurious acks (ack while the corresponding fire = 0) are ignored: no decrement.
- Inventory counters:
  - 8-bit, never wrap below 0.
  - Inventory is checked before each coin, so no decrement is attempted at 0.
- load:
  - Takes effect in any state, next cycle.
  - Overrides an ack decrement in the same cycle.
  - Does not touch FIFO, FSM or sticky flags.
- busy = (state != IDLE) | FIFO non-empty. In JAM, busy = 1.
- queue_full is combinational from the FIFO count.
- overflow, short_change and jam clear only on reset.
- Reset mid-operation: fire drops immediately (async); the queued requests are lost.

Test Plan:
- load nickels=5, dimes=5; pulse dime_out+nickel_out together; ack each fire 2 cycles after it rises → exactly 1 nickel_fire then 1 dime_fire, inventories 4/4, busy low afterwards, no sticky flags.
- load dimes=3; pulse two_dime_out; ack each fire → two separate dime_fire pulses with ≥1 low cycle between, dimes inventory 1, first fire 3 cycles after the request.
- QDEPTH=4, never ack, pulse nickel_out 6 times back-to-back → queue_full=1, overflow=1, jam=1 after TIMEOUT=15 fire cycles, nickel_fire=0 in JAM.
- load nickels=0, dimes=2; pulse nickel_out+dime_out → no nickel_fire, short_change=1, one dime_fire acked, dimes inventory 1.
- load dimes=1 in the same cycle as a dime_ack that completes a fire → inventory reads 1 (load wins); spurious dime_ack in IDLE → no change.
- Drop reset to 0 while dime_fire=1 → dime_fire, busy and jam go 0 asynchronously; FIFO is empty after release.

Source files
------------

// File: rtl/change_hopper_ctrl.sv
// change_hopper_ctrl: consumer end of the vending change interface.
// Change requests (nickel / dime / two-dime pulses) are queued in a small
// FIFO and played out as fire/ack handshakes on the nickel and dime hoppers,
// while the controller tracks coin inventory, flags short change and latches
// a sticky jam when a hopper never acknowledges a fire.
module change_hopper_ctrl #(
  parameter int QDEPTH  = 4,   // request FIFO depth, power of 2, >= 2
  parameter int TIMEOUT = 15   // fire-high cycles without ack before jam, 1..255
) (
  input  logic       clk,
  input  logic       reset,         // asynchronous, active low
  input  logic       nickel_out,
  input  logic       dime_out,
  input  logic       two_dime_out,
  input  logic       load,
  input  logic [7:0] nickels,
  input  logic [7:0] dimes,
  input  logic       nickel_ack,
  input  logic       dime_ack,
  output logic       nickel_fire,
  output logic       dime_fire,
  output logic       busy,
  output logic       queue_full,
  output logic       overflow,
  output logic       short_change,
  output logic       jam
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(QDEPTH);
  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_NFIRE = 3'd2;
  localparam logic [2:0] S_DFIRE = 3'd3;
  localparam logic [2:0] S_JAM   = 3'd4;

  // ---------------------------------------------------------------------------
  // Request FIFO. Each entry is {n, d, dd}; simultaneous pulses share one entry.
  // ---------------------------------------------------------------------------
  logic [2:0]    fifo_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       fifo_full;
  logic [2:0] head;
  logic [1:0] head_dimes;

  // FSM and handshake state
  logic [2:0] state_q, state_d;
  logic       n_rem_q, n_rem_d;
  logic [1:0] d_rem_q, d_rem_d;
  logic [7:0] timer_q, timer_d;
  logic       nfire_q, nfire_d;
  logic       dfire_q, dfire_d;

  // Inventory and sticky flags
  logic [7:0] nick_inv_q;
  logic [7:0] dime_inv_q;
  logic       overflow_q;
  logic       short_q;
  logic       short_set;
  logic       n_dec;
  logic       d_dec;

  assign push_req   = nickel_out | dime_out | two_dime_out;
  assign pop        = (state_q == S_POP);
  assign fifo_full  = (count_q == DEPTH_C);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign head       = fifo_q[rd_ptr_q];
  assign head_dimes = {1'b0, head[1]} + {head[0], 1'b0};

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write
  // NOTE: the entry array has no reset; the pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= {nickel_out, dime_out, two_dime_out};
  end

  // FIFO control registers
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispense FSM: next state, remaining coins, timer and fire levels.
  // Fire outputs are registered; POP raises the first fire directly so a lone
  // request reaches the actuator three cycles after its pulse.
  // ---------------------------------------------------------------------------
  // FSM next-state and handshake logic
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    n_rem_d   = n_rem_q;
    d_rem_d   = d_rem_q;
    timer_d   = timer_q;
    nfire_d   = nfire_q;
    dfire_d   = dfire_q;
    short_set = 1'b0;
    n_dec     = 1'b0;
    d_dec     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_POP;
      end

      S_POP: begin
        n_rem_d = head[2];
        d_rem_d = head_dimes;
        timer_d = '0;
        if (head[2]) begin
          state_d = S_NFIRE;
          nfire_d = (nick_inv_q != 8'd0);
        end else begin
          state_d = S_DFIRE;
          dfire_d = (head_dimes != 2'd0) && (dime_inv_q != 8'd0);
        end
      end

      S_NFIRE: begin
        if (!nfire_q) begin
          if (!n_rem_q) begin
            state_d = S_DFIRE;
          end else if (nick_inv_q == 8'd0) begin
            short_set = 1'b1;
            n_rem_d   = 1'b0;
            state_d   = S_DFIRE;
          end else begin
            nfire_d = 1'b1;
          end
        end else if (nickel_ack) begin
          nfire_d = 1'b0;
          n_dec   = 1'b1;
          n_rem_d = 1'b0;
          timer_d = '0;
          state_d = S_DFIRE;
        end else if (timer_q == TIMEOUT_C - 8'd1) begin
          nfire_d = 1'b0;
          state_d = S_JAM;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_DFIRE: begin
        if (!dfire_q) begin
          if (d_rem_q == 2'd0) begin
            state_d = S_IDLE;
          end else if (dime_inv_q == 8'd0) begin
            short_set = 1'b1;
            d_rem_d   = 2'd0;
            state_d   = S_IDLE;
          end else begin
            dfire_d = 1'b1;
            timer_d = '0;
          end
        end else if (dime_ack) begin
          // Fire drops for at least one cycle before the next coin.
          dfire_d = 1'b0;
          d_dec   = 1'b1;
          d_rem_d = d_rem_q - 2'd1;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_C - 8'd1) begin
          dfire_d = 1'b0;
          state_d = S_JAM;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_JAM: begin
        nfire_d = 1'b0;
        dfire_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        nfire_d = 1'b0;
        dfire_d = 1'b0;
      end
    endcase
  end

  // FSM and handshake registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_rem_q <= 1'b0;
      d_rem_q <= 2'd0;
      timer_q <= 8'd0;
      nfire_q <= 1'b0;
      dfire_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_rem_q <= n_rem_d;
      d_rem_q <= d_rem_d;
      timer_q <= timer_d;
      nfire_q <= nfire_d;
      dfire_q <= dfire_d;
    end
  end

  // Inventory counters: load wins over an ack decrement, and never wrap below 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nick_inv_q <= 8'd0;
      dime_inv_q <= 8'd0;
    end else if (load) begin
      nick_inv_q <= nickels;
      dime_inv_q <= dimes;
    end else begin
      if (n_dec && nick_inv_q != 8'd0) nick_inv_q <= nick_inv_q - 8'd1;
      if (d_dec && dime_inv_q != 8'd0) dime_inv_q <= dime_inv_q - 8'd1;
    end
  end

  // Sticky fault flags, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      if (push_req && !push_ok) overflow_q <= 1'b1;
      if (short_set)            short_q    <= 1'b1;
    end
  end

  assign nickel_fire  = nfire_q;
  assign dime_fire    = dfire_q;
  assign busy         = (state_q != S_IDLE) || (count_q != '0);
  assign queue_full   = fifo_full;
  assign overflow     = overflow_q;
  assign short_change = short_q;
  assign jam          = (state_q == S_JAM);

endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Testbench for change_hopper_ctrl: directed scenarios for the handshake,
// latency, timeout, short change and load priority, then randomized batches
// checked against a transaction-level coin-dispensing model.
module tb_change_hopper_ctrl;

  localparam int QDEPTH  = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       nickel_out, dime_out, two_dime_out;
  logic       load;
  logic [7:0] nickels, dimes;
  logic       nickel_ack, dime_ack;
  logic       nickel_fire, dime_fire, busy, queue_full;
  logic       overflow, short_change, jam;

  logic auto_n_ack, auto_d_ack;
  logic man_n_ack, man_d_ack;
  assign nickel_ack = auto_n_ack | man_n_ack;
  assign dime_ack   = auto_d_ack | man_d_ack;

  change_hopper_ctrl #(.QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .nickel_out   (nickel_out),
    .dime_out     (dime_out),
    .two_dime_out (two_dime_out),
    .load         (load),
    .nickels      (nickels),
    .dimes        (dimes),
    .nickel_ack   (nickel_ack),
    .dime_ack     (dime_ack),
    .nickel_fire  (nickel_fire),
    .dime_fire    (dime_fire),
    .busy         (busy),
    .queue_full   (queue_full),
    .overflow     (overflow),
    .short_change (short_change),
    .jam          (jam)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hopper responder: acks a fire after a fixed or random number of fire-high cycles.
  bit ack_en   = 1'b0;
  bit ack_rand = 1'b0;
  int ack_delay = 3;
  int n_wait = 0, d_wait = 0, n_tgt = 1, d_tgt = 1;

  initial begin
    auto_n_ack = 1'b0;
    auto_d_ack = 1'b0;
    forever begin
      @(negedge clk);
      auto_n_ack = 1'b0;
      auto_d_ack = 1'b0;
      if (ack_en && nickel_fire === 1'b1) begin
        if (n_wait == 0) n_tgt = ack_rand ? int'($urandom_range(1, 4)) : ack_delay;
        n_wait++;
        if (n_wait >= n_tgt) auto_n_ack = 1'b1;
      end else begin
        n_wait = 0;
      end
      if (ack_en && dime_fire === 1'b1) begin
        if (d_wait == 0) d_tgt = ack_rand ? int'($urandom_range(1, 4)) : ack_delay;
        d_wait++;
        if (d_wait >= d_tgt) auto_d_ack = 1'b1;
      end else begin
        d_wait = 0;
      end
    end
  end

  // Observer: counts fire pulses, nickel fire-high cycles and overlapping fires.
  int   n_pulses = 0, d_pulses = 0, nf_high = 0, both_hi = 0;
  logic nf_prev = 1'b0, df_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (nickel_fire === 1'b1 && nf_prev !== 1'b1) n_pulses++;
      if (dime_fire === 1'b1 && df_prev !== 1'b1)   d_pulses++;
      if (nickel_fire === 1'b1) nf_high++;
      if (nickel_fire === 1'b1 && dime_fire === 1'b1) both_hi++;
      nf_prev = nickel_fire;
      df_prev = dime_fire;
    end
  end

  task automatic clear_counts();
    n_pulses = 0;
    d_pulses = 0;
    nf_high  = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic do_load(input logic [7:0] n, input logic [7:0] d);
    load    = 1'b1;
    nickels = n;
    dimes   = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse(input logic n, input logic d, input logic dd);
    nickel_out   = n;
    dime_out     = d;
    two_dime_out = dd;
    @(negedge clk);
    nickel_out   = 1'b0;
    dime_out     = 1'b0;
    two_dime_out = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (busy !== 1'b0) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_dime_fire(input string tag, input int budget);
    int i;
    i = 0;
    while (dime_fire !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (dime_fire !== 1'b1) check({tag, "_fire_timeout"}, 32'(dime_fire), 32'd1);
  endtask

  // Transaction-level model state for the randomized batches.
  int m_n, m_d, m_short, exp_np, exp_dp;

  task automatic model_entry(input logic [2:0] r);
    int owe_d;
    owe_d = int'(r[1]) + 2 * int'(r[0]);
    if (r[2]) begin
      if (m_n == 0) m_short = 1;
      else begin m_n--; exp_np++; end
    end
    for (int c = 0; c < owe_d; c++) begin
      if (m_d == 0) begin
        m_short = 1;
        break;
      end
      m_d--;
      exp_dp++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] r;
    int k, w;

    reset = 1'b0;
    nickel_out = 1'b0; dime_out = 1'b0; two_dime_out = 1'b0;
    load = 1'b0; nickels = 8'd0; dimes = 8'd0;
    man_n_ack = 1'b0; man_d_ack = 1'b0;
    cyc(3);

    // Reset state
    check("rst_nfire",    32'(nickel_fire),    32'd0);
    check("rst_dfire",    32'(dime_fire),      32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    check("rst_qfull",    32'(queue_full),     32'd0);
    check("rst_overflow", 32'(overflow),       32'd0);
    check("rst_short",    32'(short_change),   32'd0);
    check("rst_jam",      32'(jam),            32'd0);
    check("rst_ninv",     32'(dut.nick_inv_q), 32'd0);
    check("rst_dinv",     32'(dut.dime_inv_q), 32'd0);
    reset = 1'b1;
    cyc(1);

    // Nickel + dime together, acks two cycles after each rise
    ack_en = 1'b1; ack_rand = 1'b0; ack_delay = 3;
    do_load(8'd5, 8'd5);
    clear_counts();
    pulse(1'b1, 1'b1, 1'b0);
    wait_idle("t1", 200);
    check("t1_npulses", 32'(n_pulses),        32'd1);
    check("t1_dpulses", 32'(d_pulses),        32'd1);
    check("t1_ninv",    32'(dut.nick_inv_q),  32'd4);
    check("t1_dinv",    32'(dut.dime_inv_q),  32'd4);
    check("t1_busy",    32'(busy),            32'd0);
    check("t1_flags",   32'({overflow, short_change, jam}), 32'd0);

    // Two-dime request: latency and two separate pulses
    do_load(8'd4, 8'd3);
    clear_counts();
    pulse(1'b0, 1'b0, 1'b1);
    check("t2_lat_c1", 32'(dime_fire), 32'd0);
    cyc(1);
    check("t2_lat_c2", 32'(dime_fire), 32'd0);
    cyc(1);
    check("t2_lat_c3", 32'(dime_fire), 32'd1);
    wait_idle("t2", 200);
    check("t2_dpulses", 32'(d_pulses),       32'd2);
    check("t2_npulses", 32'(n_pulses),       32'd0);
    check("t2_dinv",    32'(dut.dime_inv_q), 32'd1);
    check("t2_short",   32'(short_change),   32'd0);

    // Nickel owed with empty nickel hopper
    do_load(8'd0, 8'd2);
    clear_counts();
    pulse(1'b1, 1'b1, 1'b0);
    wait_idle("t4", 200);
    check("t4_npulses", 32'(n_pulses),       32'd0);
    check("t4_short",   32'(short_change),   32'd1);
    check("t4_dpulses", 32'(d_pulses),       32'd1);
    check("t4_dinv",    32'(dut.dime_inv_q), 32'd1);

    // Load in the same cycle as a completing ack; then spurious acks
    do_reset();
    ack_en = 1'b0;
    do_load(8'd3, 8'd5);
    clear_counts();
    pulse(1'b0, 1'b1, 1'b0);
    wait_dime_fire("t5", 10);
    man_d_ack = 1'b1;
    load = 1'b1; nickels = 8'd3; dimes = 8'd1;
    @(negedge clk);
    man_d_ack = 1'b0;
    load = 1'b0;
    wait_idle("t5", 50);
    check("t5_load_wins", 32'(dut.dime_inv_q), 32'd1);
    check("t5_dpulses",   32'(d_pulses),       32'd1);
    man_d_ack = 1'b1; man_n_ack = 1'b1;
    @(negedge clk);
    man_d_ack = 1'b0; man_n_ack = 1'b0;
    cyc(2);
    check("t5_spur_dinv", 32'(dut.dime_inv_q), 32'd1);
    check("t5_spur_ninv", 32'(dut.nick_inv_q), 32'd3);
    check("t5_spur_busy", 32'(busy),           32'd0);

    // Overflow and jam with no acks
    do_reset();
    ack_en = 1'b0;
    do_load(8'd5, 8'd0);
    clear_counts();
    nickel_out = 1'b1;
    cyc(6);
    nickel_out = 1'b0;
    check("t3_qfull",    32'(queue_full), 32'd1);
    check("t3_overflow", 32'(overflow),   32'd1);
    check("t3_nojam",    32'(jam),        32'd0);
    w = 0;
    while (jam !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("t3_jam",       32'(jam),         32'd1);
    check("t3_fire_high", 32'(nf_high),     32'(TIMEOUT));
    check("t3_nfire_jam", 32'(nickel_fire), 32'd0);
    check("t3_busy_jam",  32'(busy),        32'd1);
    cyc(3);
    check("t3_jam_stays", 32'(jam),         32'd1);
    check("t3_ninv",      32'(dut.nick_inv_q), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("t3_rst_jam",  32'(jam),        32'd0);
    check("t3_rst_busy", 32'(busy),       32'd0);
    check("t3_rst_ovf",  32'(overflow),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);

    // Async reset while dime fire is high
    do_load(8'd0, 8'd3);
    pulse(1'b0, 1'b0, 1'b1);
    wait_dime_fire("t6", 10);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_dfire", 32'(dime_fire), 32'd0);
    check("t6_rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(3);
    check("t6_post_busy",  32'(busy),       32'd0);
    check("t6_post_qfull", 32'(queue_full), 32'd0);
    check("t6_post_dfire", 32'(dime_fire),  32'd0);

    // Randomized batches against the transaction model
    do_reset();
    ack_en = 1'b1; ack_rand = 1'b1;
    m_short = 0;
    for (int b = 0; b < 20; b++) begin
      wait_idle("rnd_pre", 500);
      m_n = int'($urandom_range(0, 3));
      m_d = int'($urandom_range(0, 4));
      do_load(8'(m_n), 8'(m_d));
      clear_counts();
      exp_np = 0;
      exp_dp = 0;
      k = int'($urandom_range(1, 6));
      for (int j = 0; j < k; j++) begin
        w = 0;
        while (queue_full === 1'b1 && w < 100) begin
          @(negedge clk);
          w++;
        end
        r = 3'($urandom_range(1, 7));
        pulse(r[2], r[1], r[0]);
        model_entry(r);
        cyc(int'($urandom_range(0, 3)));
      end
      wait_idle("rnd", 1000);
      check("rnd_npulses", 32'(n_pulses),        32'(exp_np));
      check("rnd_dpulses", 32'(d_pulses),        32'(exp_dp));
      check("rnd_ninv",    32'(dut.nick_inv_q),  32'(m_n));
      check("rnd_dinv",    32'(dut.dime_inv_q),  32'(m_d));
      check("rnd_short",   32'(short_change),    32'(m_short));
      check("rnd_overflow", 32'(overflow),       32'd0);
      check("rnd_jam",     32'(jam),             32'd0);
    end

    check("fire_onehot", 32'(both_hi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
